// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction-fetch stage in front of a 1-cycle-latency imem.
//            Optional macro IFU_MISALIGN_CHECK_EN adds a misaligned-redirect
//            trap entry and the out_misalign port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_ren,
    output logic [31:0] imem_raddr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic        out_misalign
`endif
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        valid_q, valid_d;

    logic        w_fire;
    logic        w_can_issue;
    logic        w_halted;
    logic [31:0] w_target;

    assign w_target = redirect_pc & C_ALIGN_MASK;

`ifdef IFU_MISALIGN_CHECK_EN
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic halted_q, halted_d;
    logic misalign_q, misalign_d;

    assign w_halted     = halted_q;
    // The trap entry carries a NOP in place of RAM data; the RAM was never read.
    assign out_inst     = misalign_q ? C_NOP : imem_rdata;
    assign out_misalign = misalign_q & ~reset;
`else
    assign w_halted     = 1'b0;
    assign out_inst     = imem_rdata;
`endif

    always_comb begin
        out_valid     = valid_q & ~redirect_valid & ~reset;
        out_pc        = reset ? 32'h0000_0000 : inflight_pc_q;
        w_fire        = out_valid & out_ready;
        w_can_issue   = (~valid_q | w_fire) & ~w_halted;

        imem_ren      = 1'b0;
        imem_raddr    = pc_q & C_ALIGN_MASK;
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        valid_d       = valid_q;
`ifdef IFU_MISALIGN_CHECK_EN
        halted_d      = halted_q;
        misalign_d    = misalign_q & ~w_fire;
`endif

        if (redirect_valid) begin
            state_d       = ST_RUN;
            valid_d       = 1'b1;
            imem_ren      = 1'b1;
            imem_raddr    = w_target;
            inflight_pc_d = w_target;
            pc_d          = w_target + PC_STEP;
`ifdef IFU_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                imem_ren      = 1'b0;
                inflight_pc_d = redirect_pc;
                pc_d          = pc_q;
                halted_d      = 1'b1;
                misalign_d    = 1'b1;
            end else begin
                halted_d      = 1'b0;
                misalign_d    = 1'b0;
            end
`endif
        end else if (state_q == ST_BOOT) begin
            state_d       = ST_RUN;
            valid_d       = 1'b1;
            imem_ren      = 1'b1;
            imem_raddr    = RESET_PC & C_ALIGN_MASK;
            inflight_pc_d = RESET_PC & C_ALIGN_MASK;
            pc_d          = (RESET_PC & C_ALIGN_MASK) + PC_STEP;
        end else if (w_can_issue) begin
            valid_d       = 1'b1;
            imem_ren      = 1'b1;
            inflight_pc_d = pc_q & C_ALIGN_MASK;
            pc_d          = (pc_q & C_ALIGN_MASK) + PC_STEP;
        end else if (w_fire) begin
            // Only reachable while halted after a trap entry drains.
            valid_d       = 1'b0;
        end

        if (reset) begin
            imem_ren = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0000_0000;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            valid_q       <= valid_d;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Directed vector bench for ifu_fetch with a 1-cycle imem model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    localparam logic [31:0] R = 32'h8000_0000;

    logic        clock;
    logic        reset;
    logic        imem_ren;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        out_misalign;
`endif

    ifu_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .imem_ren       (imem_ren),
        .imem_raddr     (imem_raddr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .out_misalign   (out_misalign)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM contents are a fixed scramble of the address so inst differs from pc.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    always @(posedge clock) begin
        if (imem_ren) imem_rdata <= word_at(imem_raddr);
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_ren;
        logic [31:0] e_raddr;
        logic        e_val;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic e_ren,
                                input logic [31:0] e_raddr, input logic e_val,
                                input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_ren = e_ren; v.e_raddr = e_raddr; v.e_val = e_val;
        v.e_pc = e_pc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @vec %0d: got %h expected %h", name, n_vec, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        reset          = v.rst;
        out_ready      = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        #1;
        n_vec++;
        chk("imem_ren", {31'd0, imem_ren}, {31'd0, v.e_ren});
        if (v.e_ren) chk("imem_raddr", imem_raddr, v.e_raddr);
        chk("out_valid", {31'd0, out_valid}, {31'd0, v.e_val});
        if (v.e_val || v.rst) chk("out_pc", out_pc, v.e_pc);
        if (v.e_val) chk("out_inst", out_inst, v.e_mis ? 32'h0000_0013 : word_at(v.e_pc));
`ifdef IFU_MISALIGN_CHECK_EN
        chk("out_misalign", {31'd0, out_misalign}, {31'd0, v.e_mis & ~v.rst});
`endif
    endtask

    vec_t        tbl[22];
    logic [31:0] pat;
    logic [31:0] exp_next;

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        //            rst rdy rv  rpc           ren raddr         val pc            mis
        tbl[0]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        tbl[1]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        tbl[2]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        tbl[3]  = mk(0, 1, 0, 32'h0,        1, R,            0, 32'h0,        0);
        tbl[4]  = mk(0, 1, 0, 32'h0,        1, R + 32'h4,    1, R,            0);
        tbl[5]  = mk(0, 1, 0, 32'h0,        1, R + 32'h8,    1, R + 32'h4,    0);
        tbl[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, R + 32'h8,    0);
        tbl[7]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, R + 32'h8,    0);
        tbl[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, R + 32'h8,    0);
        tbl[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, R + 32'h8,    0);
        tbl[10] = mk(0, 1, 0, 32'h0,        1, R + 32'hC,    1, R + 32'h8,    0);
        tbl[11] = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, R + 32'hC,    0);
        tbl[12] = mk(0, 0, 1, R + 32'h100,  1, R + 32'h100,  0, 32'h0,        0);
        tbl[13] = mk(0, 1, 0, 32'h0,        1, R + 32'h104,  1, R + 32'h100,  0);
        tbl[14] = mk(0, 1, 0, 32'h0,        1, R + 32'h108,  1, R + 32'h104,  0);
        tbl[15] = mk(0, 1, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 0, 32'h0,     0);
        tbl[16] = mk(0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0);
        tbl[17] = mk(0, 1, 0, 32'h0,        1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);
        tbl[18] = mk(0, 1, 0, 32'h0,        1, 32'h0000_0004, 1, 32'h0000_0000, 0);
        tbl[19] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        tbl[20] = mk(0, 1, 0, 32'h0,        1, R,            0, 32'h0,        0);
        tbl[21] = mk(0, 1, 0, 32'h0,        1, R + 32'h4,    1, R,            0);

        for (int i = 0; i < 22; i++) apply(tbl[i]);

`ifdef IFU_MISALIGN_CHECK_EN
        // Misaligned redirect: trap entry held through a stall, then halt.
        apply(mk(0, 1, 1, 32'h8000_0102, 0, 32'h0, 0, 32'h0,        0));
        apply(mk(0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h8000_0102, 1));
        apply(mk(0, 1, 0, 32'h0,         0, 32'h0, 1, 32'h8000_0102, 1));
        apply(mk(0, 1, 0, 32'h0,         0, 32'h0, 0, 32'h0,        0));
        apply(mk(0, 1, 0, 32'h0,         0, 32'h0, 0, 32'h0,        0));
        apply(mk(0, 1, 1, 32'h8000_0200, 1, 32'h8000_0200, 0, 32'h0, 0));
`else
        // Unaligned target: low address bits dropped on the request.
        apply(mk(0, 1, 1, 32'h8000_0203, 1, 32'h8000_0200, 0, 32'h0, 0));
`endif
        apply(mk(0, 1, 0, 32'h0, 1, 32'h8000_0204, 1, 32'h8000_0200, 0));

        // Irregular ready pattern: every entry fires once, in order, none lost.
        pat      = 32'b1011_0011_1000_1110_1101_0001_1111_0100;
        exp_next = 32'h8000_0204;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            reset          = 1'b0;
            redirect_valid = 1'b0;
            out_ready      = pat[i];
            #1;
            n_vec++;
            chk("sb_valid", {31'd0, out_valid}, 32'd1);
            chk("sb_ren", {31'd0, imem_ren}, {31'd0, pat[i]});
            chk("sb_pc", out_pc, exp_next);
            chk("sb_inst", out_inst, word_at(exp_next));
            if (pat[i]) exp_next = exp_next + 32'h4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
